// File: rtl/mu_fifo_async_pkt.sv
// Dual-clock FWFT FIFO with packet commit (wr_last) and abort on the write side; beats carry {last, data}.
// Define MU_FIFO_ASYNC_PKT_LEVEL_EN to add registered wr_level / rd_level occupancy outputs.
module mu_fifo_async_pkt #(
  parameter int DW           = 16,
  parameter int DEPTH        = 16,
  parameter int PKT_MODE     = 1,
  parameter int THRESH_FULL  = DEPTH - 2,
  parameter int THRESH_EMPTY = 1
) (
  input  logic                  wr_clk,
  input  logic                  wr_nreset,
  input  logic                  rd_clk,
  input  logic                  rd_nreset,
  input  logic [DW-1:0]         wr_din,
  input  logic                  wr_last,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  wr_abort,
  output logic                  wr_almost_full,
  output logic                  wr_oversize,
  output logic [DW-1:0]         rd_dout,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_almost_empty
`ifdef MU_FIFO_ASYNC_PKT_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] wr_level,
  output logic [$clog2(DEPTH):0] rd_level
`endif
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;
  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
  localparam ptr_t TH_F    = ptr_t'(THRESH_FULL);
  localparam ptr_t TH_E    = ptr_t'(THRESH_EMPTY);

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [DW:0] ram [DEPTH];

  // ---------------- write domain ----------------
  ptr_t wr_ptr, wr_cptr, wr_ptr_nxt, wr_cptr_nxt, wr_cgray;
  ptr_t rp_gray_s1, rp_gray_s2, rd_ptr_sync, wr_occ;
  ptr_t rd_gray;
  logic accept, abort_en;

  assign rd_ptr_sync = gray2bin(rp_gray_s2);
  assign wr_occ      = wr_ptr - rd_ptr_sync;
  assign wr_ready    = (wr_occ != DEPTH_P);
  assign accept      = wr_valid && wr_ready;
  assign abort_en    = (PKT_MODE != 0) && wr_abort;

  // Abort wins over a beat in the same cycle, even one carrying wr_last.
  always_comb begin
    wr_ptr_nxt  = wr_ptr;
    wr_cptr_nxt = wr_cptr;
    if (abort_en) begin
      wr_ptr_nxt = wr_cptr;
    end else if (accept) begin
      wr_ptr_nxt = wr_ptr + ptr_t'(1);
      if ((PKT_MODE == 0) || wr_last) wr_cptr_nxt = wr_ptr + ptr_t'(1);
    end
  end

  always_ff @(posedge wr_clk) begin
    if (accept) ram[wr_ptr[AW-1:0]] <= {wr_last, wr_din};
  end

  always_ff @(posedge wr_clk or negedge wr_nreset) begin
    if (!wr_nreset) begin
      wr_ptr         <= '0;
      wr_cptr        <= '0;
      wr_cgray       <= '0;
      rp_gray_s1     <= '0;
      rp_gray_s2     <= '0;
      wr_almost_full <= 1'b0;
      wr_oversize    <= 1'b0;
    end else begin
      wr_ptr         <= wr_ptr_nxt;
      wr_cptr        <= wr_cptr_nxt;
      wr_cgray       <= bin2gray(wr_cptr_nxt);
      rp_gray_s1     <= rd_gray;
      rp_gray_s2     <= rp_gray_s1;
      wr_almost_full <= (wr_occ >= TH_F);
      if ((wr_ptr - wr_cptr) == DEPTH_P) wr_oversize <= 1'b1;
    end
  end

  // ---------------- read domain ----------------
  // rd_ptr counts popped entries; the output register holds ram[rd_ptr] while rd_valid.
  ptr_t rd_ptr, rd_ptr_nxt, wp_gray_s1, wp_gray_s2, wr_cptr_sync, rd_occ;
  logic pop, load, rd_valid_nxt;

  assign wr_cptr_sync = gray2bin(wp_gray_s2);
  assign rd_occ       = wr_cptr_sync - rd_ptr;
  assign pop          = rd_valid && rd_ready;

  always_comb begin
    rd_ptr_nxt   = rd_ptr + ptr_t'(pop);
    load         = (rd_ptr_nxt != wr_cptr_sync) && (pop || !rd_valid);
    rd_valid_nxt = load || (rd_valid && !rd_ready);
  end

  always_ff @(posedge rd_clk or negedge rd_nreset) begin
    if (!rd_nreset) begin
      rd_ptr          <= '0;
      rd_gray         <= '0;
      wp_gray_s1      <= '0;
      wp_gray_s2      <= '0;
      rd_valid        <= 1'b0;
      rd_dout         <= '0;
      rd_last         <= 1'b0;
      rd_almost_empty <= 1'b1;
    end else begin
      rd_ptr          <= rd_ptr_nxt;
      rd_gray         <= bin2gray(rd_ptr_nxt);
      wp_gray_s1      <= wr_cgray;
      wp_gray_s2      <= wp_gray_s1;
      rd_valid        <= rd_valid_nxt;
      if (load) {rd_last, rd_dout} <= ram[rd_ptr_nxt[AW-1:0]];
      rd_almost_empty <= (rd_occ <= TH_E);
    end
  end

`ifdef MU_FIFO_ASYNC_PKT_LEVEL_EN
  always_ff @(posedge wr_clk or negedge wr_nreset) begin
    if (!wr_nreset) wr_level <= '0;
    else            wr_level <= wr_occ;
  end

  always_ff @(posedge rd_clk or negedge rd_nreset) begin
    if (!rd_nreset) rd_level <= '0;
    else            rd_level <= rd_occ;
  end
`endif

endmodule

// File: tb/tb_mu_fifo_async_pkt.sv
// Bench for mu_fifo_async_pkt: PKT_MODE=1 instance for packet tests, PKT_MODE=0 instance for streaming.
`timescale 1ns/1ps
module tb_mu_fifo_async_pkt;

  logic wr_clk = 1'b0;
  logic rd_clk = 1'b0;
  logic wr_nreset = 1'b0;
  logic rd_nreset = 1'b0;
  always #5 wr_clk = ~wr_clk;
  always #18.519 rd_clk = ~rd_clk;

  logic [15:0] wr_din = '0;
  logic wr_last = 1'b0, wr_valid = 1'b0, wr_abort = 1'b0, rd_ready = 1'b0;
  logic wr_ready, wr_almost_full, wr_oversize, rd_last, rd_valid, rd_almost_empty;
  logic [15:0] rd_dout;

  logic [15:0] m0_wr_din = '0;
  logic m0_wr_last = 1'b0, m0_wr_valid = 1'b0, m0_wr_abort = 1'b0, m0_rd_ready = 1'b0;
  logic m0_wr_ready, m0_wr_almost_full, m0_wr_oversize, m0_rd_last, m0_rd_valid, m0_rd_almost_empty;
  logic [15:0] m0_rd_dout;
`ifdef MU_FIFO_ASYNC_PKT_LEVEL_EN
  logic [4:0] wr_level, rd_level, m0_wr_level, m0_rd_level;
`endif

  mu_fifo_async_pkt #(.DW(16), .DEPTH(16), .PKT_MODE(1)) u_pkt (
    .wr_clk(wr_clk), .wr_nreset(wr_nreset), .rd_clk(rd_clk), .rd_nreset(rd_nreset),
    .wr_din(wr_din), .wr_last(wr_last), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_abort(wr_abort), .wr_almost_full(wr_almost_full), .wr_oversize(wr_oversize),
    .rd_dout(rd_dout), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_almost_empty(rd_almost_empty)
`ifdef MU_FIFO_ASYNC_PKT_LEVEL_EN
    , .wr_level(wr_level), .rd_level(rd_level)
`endif
  );

  mu_fifo_async_pkt #(.DW(16), .DEPTH(16), .PKT_MODE(0)) u_str (
    .wr_clk(wr_clk), .wr_nreset(wr_nreset), .rd_clk(rd_clk), .rd_nreset(rd_nreset),
    .wr_din(m0_wr_din), .wr_last(m0_wr_last), .wr_valid(m0_wr_valid), .wr_ready(m0_wr_ready),
    .wr_abort(m0_wr_abort), .wr_almost_full(m0_wr_almost_full), .wr_oversize(m0_wr_oversize),
    .rd_dout(m0_rd_dout), .rd_last(m0_rd_last), .rd_valid(m0_rd_valid), .rd_ready(m0_rd_ready),
    .rd_almost_empty(m0_rd_almost_empty)
`ifdef MU_FIFO_ASYNC_PKT_LEVEL_EN
    , .wr_level(m0_wr_level), .rd_level(m0_rd_level)
`endif
  );

  int total = 0;
  int bad = 0;
  int rd_mode = 0;           // 0 hold, 1 always ready, 2 random ready, 3 pop one then hold
  logic [16:0] got[$];

  task automatic chk_eq(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_le(input string nm, input int act, input int lim);
    total++;
    if (act > lim) begin
      bad++;
      $display("FAIL %s: got %0d want <= %0d", nm, act, lim);
    end
  endtask

  // Reader for the packet instance: every pop lands in got as {last, data}.
  initial begin
    bit r;
    forever begin
      @(negedge rd_clk);
      case (rd_mode)
        1: r = 1'b1;
        2: r = ($urandom_range(3) != 0);
        3: begin r = 1'b1; rd_mode = 0; end
        default: r = 1'b0;
      endcase
      rd_ready = r;
      if (rd_valid && r) got.push_back({rd_last, rd_dout});
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, want finish earlier");
    $fatal(1);
  end

  task automatic wr_cycle(input bit sel, input bit v, input logic [15:0] d, input bit l,
                          input bit ab, output bit acc);
    @(negedge wr_clk);
    if (sel) begin m0_wr_valid = v; m0_wr_din = d; m0_wr_last = l; m0_wr_abort = ab; end
    else     begin wr_valid = v;    wr_din = d;    wr_last = l;    wr_abort = ab;    end
    acc = v && (sel ? m0_wr_ready : wr_ready);
    @(posedge wr_clk);
    #1;
    if (sel) begin m0_wr_valid = 1'b0; m0_wr_abort = 1'b0; end
    else     begin wr_valid = 1'b0;    wr_abort = 1'b0;    end
  endtask

  task automatic wr_op(input bit sel, input logic [15:0] d, input bit l, output bit acc);
    int n;
    n = 0;
    wr_cycle(sel, 1'b1, d, l, 1'b0, acc);
    while (!acc && n < 3000) begin
      wr_cycle(sel, 1'b1, d, l, 1'b0, acc);
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL wr_accept_timeout: ready low for %0d cycles, want accept", n);
    end
  endtask

  task automatic wait_got(input string nm, input int n, input int budget);
    int k;
    k = 0;
    while (got.size() < n && k < budget) begin
      @(posedge rd_clk);
      k++;
    end
    repeat (20) @(posedge rd_clk);
    chk_eq(nm, got.size(), n);
  endtask

  task automatic wr_idle(input int n);
    repeat (n) @(posedge wr_clk);
    #1;
  endtask

  task automatic rd_idle(input int n);
    repeat (n) @(posedge rd_clk);
    #1;
  endtask

  typedef struct {
    bit          vld;
    logic [15:0] din;
    bit          last;
    bit          abort;
    bit          exp_rd;
  } vec_t;

  initial begin
    vec_t vt[10];
    logic [16:0] exp_q[$];
    logic [16:0] pend[$];
    logic [15:0] m0q[$];
    logic [15:0] d;
    bit l, acc;
    int n, amode, ak, j, k, errs, first;

    vt[0] = '{1'b1, 16'h1111, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 16'h2222, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b1, 16'h3333, 1'b1, 1'b1, 1'b0};
    vt[3] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    vt[4] = '{1'b1, 16'h0D0D, 1'b1, 1'b0, 1'b1};
    vt[5] = '{1'b1, 16'h5555, 1'b0, 1'b0, 1'b1};
    vt[6] = '{1'b1, 16'h6666, 1'b1, 1'b0, 1'b1};
    vt[7] = '{1'b1, 16'h7777, 1'b0, 1'b0, 1'b0};
    vt[8] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    vt[9] = '{1'b1, 16'h9999, 1'b1, 1'b0, 1'b1};

    // Reset values
    #100;
    chk_eq("rst_wr_ready", wr_ready, 1);
    chk_eq("rst_wr_almost_full", wr_almost_full, 0);
    chk_eq("rst_wr_oversize", wr_oversize, 0);
    chk_eq("rst_rd_valid", rd_valid, 0);
    chk_eq("rst_rd_dout", rd_dout, 0);
    chk_eq("rst_rd_last", rd_last, 0);
    chk_eq("rst_rd_almost_empty", rd_almost_empty, 1);
    wr_nreset = 1'b1;
    rd_nreset = 1'b1;
    wr_idle(4);

    // A,B stay invisible until C commits the packet
    got.delete();
    wr_op(0, 16'h00A0, 1'b0, acc);
    wr_op(0, 16'h00B0, 1'b0, acc);
    rd_idle(10);
    chk_eq("uncommitted_rd_valid", rd_valid, 0);
    wr_op(0, 16'h00C0, 1'b1, acc);
    n = 0;
    while (n < 8) begin
      @(posedge rd_clk);
      n++;
      #1;
      if (rd_valid) break;
    end
    chk_le("commit_latency", n, 4);
    chk_eq("head_dout", rd_dout, 16'h00A0);
    rd_idle(5);
    chk_eq("hold_dout", rd_dout, 16'h00A0);
    chk_eq("hold_last", rd_last, 0);
    chk_eq("hold_valid", rd_valid, 1);
    chk_eq("occ3_almost_empty", rd_almost_empty, 0);
    rd_mode = 1;
    wait_got("abc_count", 3, 200);
    chk_eq("abc_0", (got.size() > 0) ? int'(got[0]) : -1, {1'b0, 16'h00A0});
    chk_eq("abc_1", (got.size() > 1) ? int'(got[1]) : -1, {1'b0, 16'h00B0});
    chk_eq("abc_2", (got.size() > 2) ? int'(got[2]) : -1, {1'b1, 16'h00C0});
    chk_eq("drained_almost_empty", rd_almost_empty, 1);

    // Table: aborts, abort with last, abort with nothing open
    got.delete();
    for (int i = 0; i < 10; i++) begin
      if (vt[i].abort) wr_cycle(0, vt[i].vld, vt[i].din, vt[i].last, 1'b1, acc);
      else             wr_op(0, vt[i].din, vt[i].last, acc);
    end
    n = 0;
    for (int i = 0; i < 10; i++) if (vt[i].exp_rd) n++;
    wait_got("vec_count", n, 400);
    j = 0;
    for (int i = 0; i < 10; i++) begin
      if (vt[i].exp_rd) begin
        chk_eq($sformatf("vec_%0d", i), (got.size() > j) ? int'(got[j]) : -1,
               {vt[i].last, vt[i].din});
        j++;
      end
    end

    // Fill 16 committed beats with no reads
    rd_mode = 0;
    got.delete();
    rd_idle(6);
    for (int i = 0; i < 13; i++) wr_op(0, 16'h0100 + 16'(i), 1'b1, acc);
    wr_idle(3);
    chk_eq("occ13_almost_full", wr_almost_full, 0);
    wr_op(0, 16'h010D, 1'b1, acc);
    wr_idle(3);
    chk_eq("occ14_almost_full", wr_almost_full, 1);
    chk_eq("occ14_wr_ready", wr_ready, 1);
    wr_op(0, 16'h010E, 1'b1, acc);
    wr_op(0, 16'h010F, 1'b1, acc);
    wr_idle(3);
    chk_eq("full_wr_ready", wr_ready, 0);
    rd_idle(6);
    chk_eq("full_rd_valid", rd_valid, 1);
    chk_eq("full_head", rd_dout, 16'h0100);
    chk_eq("full_almost_empty", rd_almost_empty, 0);
    rd_mode = 3;
    wait (rd_mode == 0);
    @(posedge rd_clk);
    n = 0;
    while (n < 8) begin
      @(posedge wr_clk);
      n++;
      #1;
      if (wr_ready) break;
    end
    chk_le("space_latency", n, 3);
    rd_mode = 1;
    wait_got("fill_count", 16, 400);
    for (int i = 0; i < 16; i++)
      chk_eq($sformatf("fill_%0d", i), (got.size() > i) ? int'(got[i]) : -1,
             {1'b1, 16'h0100 + 16'(i)});
    wr_idle(4);
    chk_eq("fill_drained_almost_full", wr_almost_full, 0);

    // Oversize: 16 beats without wr_last
    got.delete();
    for (int i = 0; i < 16; i++) wr_op(0, 16'h0200 + 16'(i), 1'b0, acc);
    wr_idle(2);
    chk_eq("oversize_set", wr_oversize, 1);
    chk_eq("oversize_wr_ready", wr_ready, 0);
    wr_cycle(0, 1'b0, 16'h0, 1'b0, 1'b1, acc);
    wr_idle(2);
    chk_eq("abort_wr_ready", wr_ready, 1);
    chk_eq("oversize_sticky", wr_oversize, 1);
    wr_op(0, 16'h02AA, 1'b1, acc);
    wait_got("post_abort_count", 1, 200);
    chk_eq("post_abort_data", (got.size() > 0) ? int'(got[0]) : -1, {1'b1, 16'h02AA});
    chk_eq("oversize_still", wr_oversize, 1);

    // Reset clears the sticky flag
    rd_mode = 0;
    wr_nreset = 1'b0;
    rd_nreset = 1'b0;
    #50;
    chk_eq("rst2_oversize", wr_oversize, 0);
    chk_eq("rst2_rd_valid", rd_valid, 0);
    wr_nreset = 1'b1;
    rd_nreset = 1'b1;
    wr_idle(4);

    // Random packets with random aborts and random rd_ready
    got.delete();
    exp_q.delete();
    pend.delete();
    rd_mode = 2;
    for (int p = 0; p < 1000; p++) begin
      n = $urandom_range(8, 1);
      amode = ($urandom_range(7) == 0) ? $urandom_range(2, 1) : 0;
      ak = $urandom_range(n - 1, 0);
      for (int b = 0; b < n; b++) begin
        d = 16'($urandom);
        l = (b == n - 1);
        if (amode == 2 && b == ak && b > 0) begin
          wr_cycle(0, 1'b0, 16'h0, 1'b0, 1'b1, acc);
          pend.delete();
        end
        if (amode == 1 && b == ak) begin
          wr_cycle(0, 1'b1, d, l, 1'b1, acc);
          pend.delete();
          break;
        end
        wr_op(0, d, l, acc);
        if (acc) begin
          pend.push_back({l, d});
          if (l) begin
            foreach (pend[q]) exp_q.push_back(pend[q]);
            pend.delete();
          end
        end
        if ($urandom_range(3) == 0) @(negedge wr_clk);
      end
    end
    wait_got("rand_count", exp_q.size(), 30000);
    errs = 0;
    first = -1;
    k = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < k; i++) begin
      if (got[i] !== exp_q[i]) begin
        errs++;
        if (first < 0) first = i;
      end
    end
    if (first >= 0) $display("first random difference at beat %0d", first);
    chk_eq("rand_data_diffs", errs, 0);

    // PKT_MODE=0: beats readable without wr_last, abort ignored
    wr_op(1, 16'h0101, 1'b0, acc);
    n = 0;
    while (n < 8) begin
      @(posedge rd_clk);
      n++;
      #1;
      if (m0_rd_valid) break;
    end
    chk_le("stream_latency", n, 4);
    wr_cycle(1, 1'b1, 16'h0202, 1'b0, 1'b1, acc);
    wr_cycle(1, 1'b0, 16'h0000, 1'b0, 1'b1, acc);
    wr_op(1, 16'h0303, 1'b0, acc);
    wr_op(1, 16'h0404, 1'b1, acc);
    wr_op(1, 16'h0505, 1'b0, acc);
    rd_idle(12);
`ifdef MU_FIFO_ASYNC_PKT_LEVEL_EN
    chk_eq("stream_wr_level", m0_wr_level, 5);
    chk_eq("stream_rd_level", m0_rd_level, 5);
`endif
    m0q.delete();
    k = 0;
    while (m0q.size() < 5 && k < 100) begin
      @(negedge rd_clk);
      m0_rd_ready = 1'b1;
      if (m0_rd_valid) m0q.push_back(m0_rd_dout);
      k++;
    end
    @(negedge rd_clk);
    m0_rd_ready = 1'b0;
    rd_idle(10);
    chk_eq("stream_count", m0q.size(), 5);
    for (int i = 0; i < 5; i++)
      chk_eq($sformatf("stream_%0d", i), (m0q.size() > i) ? int'(m0q[i]) : -1,
             (i + 1) * 16'h0101);
    chk_eq("stream_empty_after", m0_rd_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mu_fifo_async_pkt.md
Name: mu_fifo_async_pkt

Overview:
- Dual-clock asynchronous FIFO with packet commit/abort on the write side and first-word-fall-through (FWFT) output on the read side.
- Carries DW data bits plus a last flag per beat.
- Successor to the streaming async FIFO, for sensor-frame and UART/I2C burst transfers that must be dropped whole on error.
- Sits between the capture clock domain and the pixel/system clock domain.

Parameters:
- DW, 16, data width in bits.
- DEPTH, 16, entries; power of two, minimum 2.
- PKT_MODE, 1. 1: beats become readable only after wr_last commit. 0: every beat commits on acceptance and wr_abort is ignored.
- THRESH_FULL, DEPTH-2, wr_almost_full threshold on write-side occupancy.
- THRESH_EMPTY, 1, rd_almost_empty threshold on read-side occupancy.

Ports:
- wr_clk  in  1  write clock
- wr_nreset  in  1  write-domain reset, asynchronous, active-low
- rd_clk  in  1  read clock
- rd_nreset  in  1  read-domain reset, asynchronous, active-low
- wr_din  in  DW  write data
- wr_last  in  1  last beat of packet
- wr_valid  in  1  write request
- wr_ready  out  1  space available
- wr_abort  in  1  discard the uncommitted packet
- wr_almost_full  out  1  occupancy >= THRESH_FULL
- wr_oversize  out  1  sticky: packet cannot fit in DEPTH
- rd_dout  out  DW  head data
- rd_last  out  1  head last flag
- rd_valid  out  1  head valid
- rd_ready  in  1  pop head
- rd_almost_empty  out  1  occupancy <= THRESH_EMPTY

Behaviour:
- Reset values:
  - wr_nreset low: all write pointers = 0, wr_ready = 1, wr_almost_full = 0 (THRESH_FULL > 0), wr_oversize = 0.
  - rd_nreset low: read pointers = 0, rd_valid = 0, rd_dout = 0, rd_last = 0, rd_almost_empty = 1.
  - Both resets are asserted together at system level. Single-side reset mid-operation is illegal; the FIFO contents are undefined until both resets are applied.
- Pointers:
  - AW = log2(DEPTH). All pointers are AW+1 bits binary and wrap naturally; RAM is indexed with the low AW bits.
  - Write side keeps wr_ptr (next write) and wr_cptr (committed).
  - The gray code of wr_cptr is synchronised to rd_clk through 2 flops per bit.
  - The gray code of rd_ptr is synchronised to wr_clk through 2 flops per bit.
  - Synchronised gray values are converted back to binary for occupancy arithmetic.
- Write handshake:
  - A beat is accepted when wr_valid && wr_ready on a wr_clk edge. The {wr_last, wr_din} word is written to ram[wr_ptr] and wr_ptr is incremented.
  - wr_ready = (wr_ptr - rd_ptr_sync) != DEPTH. It is computed only from registered pointers, with no combinational path from wr_valid.
  - PKT_MODE=1: an accepted beat with wr_last sets wr_cptr <= wr_ptr+1 in the same edge.
  - PKT_MODE=0: wr_cptr tracks wr_ptr+accept every cycle.
- Abort:
  - wr_abort high on an edge sets wr_ptr <= wr_cptr.
  - An accepted beat in the same cycle is discarded, including one carrying wr_last; abort has priority.
  - Abort with no open packet has no effect.
- Oversize:
  - wr_oversize sets when wr_ptr - wr_cptr == DEPTH, i.e. an uncommitted packet fills the RAM.
  - It clears only on reset. The writer must wr_abort to recover.
- wr_almost_full: (wr_ptr - rd_ptr_sync) >= THRESH_FULL, registered, one wr_clk lag.
- Read side (FWFT):
  - Empty when the synchronised wr_cptr equals rd_ptr.
  - An output register holds the head; rd_valid, rd_dout and rd_last are all registered.
  - On a pop (rd_valid && rd_ready), or when rd_valid=0 and an entry is available, the register loads the next entry the following edge. Back-to-back pops sustain 1 beat/rd_clk.
  - rd_dout and rd_last hold while rd_valid && !rd_ready.
- Latency: a commit edge in wr_clk appears as rd_valid=1 no later than 4 rd_clk edges later (2 sync, 1 compare/read, 1 output).
- Space latency: a pop frees space, and wr_ready reasserts within 3 wr_clk edges.
- rd_almost_empty: (wr_cptr_sync - rd_ptr) <= THRESH_EMPTY, counting the entry in the output register, registered.
- Simultaneous read/write at full or empty: pointer comparisons use synchronised values only, so the FIFO is never falsely non-full or non-empty.

Optional Feature:
- Macro MU_FIFO_ASYNC_PKT_LEVEL_EN.
- When defined, adds ports wr_level out AW+1 (wr_ptr - rd_ptr_sync, registered) and rd_level out AW+1 (committed entries visible to the read side, including the output register, registered). Both reset to 0.
- When undefined, these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset, DEPTH=16, PKT_MODE=1. Write 3 beats A,B,C with wr_last on C -> rd_valid stays 0 until C commits, then rises within 4 rd_clk. Read yields A,B,C with rd_last=0,0,1.
- Write 2 beats, then wr_abort with a 3rd beat present -> nothing is ever read. A subsequent 1-beat packet D is read as D with rd_last=1.
- wr_clk 100 MHz, rd_clk 27 MHz. Stream 1000 random packets of 1-8 beats, with random rd_ready and random aborts -> the read sequence exactly matches the committed packets, with no loss or duplication.
- Fill 16 committed beats with no reads -> wr_ready=0 after 16 accepts and wr_almost_full=1 at occupancy 14. A single pop -> wr_ready=1 within 3 wr_clk.
- Write 16 beats without wr_last -> wr_oversize=1 and wr_ready=0. wr_abort -> wr_ready=1 and wr_oversize stays 1 until reset.
- PKT_MODE=0: each accepted beat becomes readable within 4 rd_clk and wr_abort has no effect. With MU_FIFO_ASYNC_PKT_LEVEL_EN defined, wr_level and rd_level settle to 5 after 5 writes and no reads.
